// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizes for the complete stage and its consumers.
// Packet layouts match the bus seen by the RS, ROB and map table.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_FU = 4;
    localparam int CDB_DEPTH  = 2;
    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
        logic                  take_branch;
    } cdb_packet_t;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
        logic                  take_branch;
    } fu_result_packet_t;

    // Pointer width for a power-of-two ring of n slots, never zero.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result buffer: power-of-two ring with occupancy count.
// Flush empties it in one edge; stored payloads are left as garbage.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int WIDTH = CDB_TAG_W + CDB_DATA_W + 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    // A full buffer refuses a push even when it is popped this cycle.
    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/cdb_arbiter.sv
// Complete stage: buffers FU results and broadcasts one per cycle on the
// common data bus under round-robin priority, with squash flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int DEPTH  = CDB_DEPTH,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    input  logic [NUM_FU-1:0]        fu_take_branch,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_value,
    output logic                     cdb_take_branch,
    output logic                     is_stall
);

    localparam int PTR_W = ptr_w(NUM_FU);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              take_branch;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t           head [NUM_FU];
    logic [CNT_W-1:0] count [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] req;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic              grant_found;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_ready[i] = count[i] < CNT_W'(DEPTH);
        assign req[i]      = count[i] != '0;
        assign push[i]     = fu_valid[i] && fu_ready[i];
        assign pop[i]      = grant_found && (grant_idx == PTR_W'(i));

        cdb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (push[i]),
            .push_data ({fu_tag[i*TAG_W +: TAG_W],
                         fu_value[i*DATA_W +: DATA_W],
                         fu_take_branch[i]}),
            .pop       (pop[i]),
            .head_data (head[i]),
            .count     (count[i])
        );
    end

    // Scan starts at rr_ptr; the ring width wraps because NUM_FU is 2^n.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        scan_idx    = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = rr_ptr + PTR_W'(k);
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Squash kills the bus and buffers but keeps the fairness pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr          <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_take_branch <= 1'b0;
        end else if (squash) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_found;
            if (grant_found) begin
                cdb_tag         <= head[grant_idx].tag;
                cdb_value       <= head[grant_idx].value;
                cdb_take_branch <= head[grant_idx].take_branch;
                rr_ptr          <= grant_idx + PTR_W'(1);
            end
        end
    end

    assign is_stall = ~&fu_ready;

    no_push_when_full: assert property (
        @(posedge clock) disable iff (reset || squash)
        !(|(fu_valid & ~fu_ready))
    );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: scoreboard on the bus plus table-driven bursts
// and hand-written back-pressure, squash and reset sequences.
module tb_cdb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic [3:0]  fu_valid;
    logic [19:0] fu_tag;
    logic [127:0] fu_value;
    logic [3:0]  fu_take_branch;
    logic [3:0]  fu_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_take_branch;
    logic        is_stall;

    always #5 clock = ~clock;

    cdb_arbiter #(
        .NUM_FU (4),
        .DEPTH  (2),
        .TAG_W  (5),
        .DATA_W (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (fu_valid),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_take_branch  (fu_take_branch),
        .fu_ready        (fu_ready),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_take_branch (cdb_take_branch),
        .is_stall        (is_stall)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] value;
        logic        tb;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic [4:0] base;
        int         n;
        logic [4:0] seq [4];
    } vec_t;

    exp_t sb [$];
    exp_t got_e;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [31:0] mkval(input logic [4:0] t);
        return 32'hA500_0000 | (32'(t) << 12) | 32'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        fu_valid       = '0;
        fu_tag         = '0;
        fu_value       = '0;
        fu_take_branch = '0;
    endtask

    task automatic drive(input int i, input logic [4:0] tag,
                         input logic [31:0] val, input logic tb);
        fu_valid[i]             = 1'b1;
        fu_tag[i*5 +: 5]        = tag;
        fu_value[i*32 +: 32]    = val;
        fu_take_branch[i]       = tb;
    endtask

    task automatic expect_bus(input logic [4:0] tag, input logic [31:0] val,
                              input logic tb);
        exp_t e;
        e.tag   = tag;
        e.value = val;
        e.tb    = tb;
        sb.push_back(e);
    endtask

    task automatic drive_exp(input int i, input logic [4:0] tag);
        drive(i, tag, mkval(tag), tag[0]);
        expect_bus(tag, mkval(tag), tag[0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 40) begin
            step();
            c++;
        end
        step();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_valid"}, 64'(cdb_valid), 64'd0);
        chk({pfx, "_tag"}, 64'(cdb_tag), 64'd0);
        chk({pfx, "_value"}, 64'(cdb_value), 64'd0);
        chk({pfx, "_br"}, 64'(cdb_take_branch), 64'd0);
        chk({pfx, "_ready"}, 64'(fu_ready), 64'hF);
        chk({pfx, "_stall"}, 64'(is_stall), 64'd0);
    endtask

    // Every broadcast must be the next expected result, in order.
    always @(negedge clock) begin
        if (cdb_valid === 1'b1) begin
            n_checks++;
            got_e = {cdb_tag, cdb_value, cdb_take_branch};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL bus_unexpected: got tag %0d, expected none",
                         cdb_tag);
            end else begin
                mon_e = sb.pop_front();
                if (got_e !== mon_e) begin
                    n_fail++;
                    $display("FAIL bus_data: got %0h, expected %0h",
                             got_e, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [4];
        int   a;
        int   b;
        logic da;
        logic db;

        vt[0].mask = 4'b1111; vt[0].base = 5'd1;  vt[0].n = 4;
        vt[0].seq  = '{5'd1, 5'd2, 5'd3, 5'd4};
        vt[1].mask = 4'b1010; vt[1].base = 5'd8;  vt[1].n = 2;
        vt[1].seq  = '{5'd9, 5'd11, 5'd0, 5'd0};
        vt[2].mask = 4'b0100; vt[2].base = 5'd16; vt[2].n = 1;
        vt[2].seq  = '{5'd18, 5'd0, 5'd0, 5'd0};
        vt[3].mask = 4'b1001; vt[3].base = 5'd20; vt[3].n = 2;
        vt[3].seq  = '{5'd20, 5'd23, 5'd0, 5'd0};

        reset  = 1'b1;
        squash = 1'b0;
        clear_in();
        do_reset();
        chk_reset_vals("reset");

        // single result on FU2
        drive(2, 5'd5, 32'hDEAD, 1'b0);
        expect_bus(5'd5, 32'hDEAD, 1'b0);
        step();
        clear_in();
        chk("single_e0_valid", 64'(cdb_valid), 64'd0);
        step();
        chk("single_e1_valid", 64'(cdb_valid), 64'd1);
        chk("single_e1_tag", 64'(cdb_tag), 64'd5);
        step();
        chk("single_e2_valid", 64'(cdb_valid), 64'd0);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // simultaneous bursts from reset, drained lowest FU first
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                if (vt[v].mask[i]) begin
                    drive_exp(i, 5'(vt[v].base + 5'(i)));
                end
            end
            step();
            clear_in();
            chk($sformatf("vec%0d_stall", v), 64'(is_stall), 64'd0);
            for (int k = 0; k < vt[v].n; k++) begin
                step();
                chk($sformatf("vec%0d_valid%0d", v, k), 64'(cdb_valid), 64'd1);
                chk($sformatf("vec%0d_tag%0d", v, k), 64'(cdb_tag),
                    64'(vt[v].seq[k]));
            end
            step();
            chk($sformatf("vec%0d_idle", v), 64'(cdb_valid), 64'd0);
            chk($sformatf("vec%0d_sb", v), 64'(sb.size()), 64'd0);
        end

        // fairness: FU0 and FU3 push whenever ready, grants alternate
        do_reset();
        for (int k = 0; k < 6; k++) begin
            expect_bus(5'(k), mkval(5'(k)), 1'(k));
            expect_bus(5'(16 + k), mkval(5'(16 + k)), 1'(k));
        end
        a = 0;
        b = 0;
        for (int cyc = 0; cyc < 100 && (a < 6 || b < 6); cyc++) begin
            clear_in();
            da = (a < 6) && fu_ready[0];
            db = (b < 6) && fu_ready[3];
            if (da) drive(0, 5'(a), mkval(5'(a)), 1'(a));
            if (db) drive(3, 5'(16 + b), mkval(5'(16 + b)), 1'(b));
            step();
            if (da) a++;
            if (db) b++;
        end
        clear_in();
        chk("fair_pushed", 64'(a + b), 64'd12);
        drain("fair_drain");

        // back-pressure on FU1
        do_reset();
        drive_exp(0, 5'd10);
        drive_exp(1, 5'd11);
        step();
        clear_in();
        chk("bp_ready_e0", 64'(fu_ready), 64'hF);
        chk("bp_stall_e0", 64'(is_stall), 64'd0);
        drive_exp(1, 5'd12);
        step();
        clear_in();
        chk("bp_ready1_full", 64'(fu_ready[1]), 64'd0);
        chk("bp_stall_full", 64'(is_stall), 64'd1);
        chk("bp_tag_fu0", 64'(cdb_tag), 64'd10);
        step();
        chk("bp_ready1_back", 64'(fu_ready[1]), 64'd1);
        chk("bp_stall_back", 64'(is_stall), 64'd0);
        drive_exp(1, 5'd13);
        step();
        clear_in();
        drain("bp_drain");

        // squash with five buffered entries and a same-cycle push
        do_reset();
        drive_exp(0, 5'd1);
        drive(1, 5'd2, mkval(5'd2), 1'b0);
        drive(2, 5'd3, mkval(5'd3), 1'b1);
        drive(3, 5'd4, mkval(5'd4), 1'b0);
        step();
        clear_in();
        drive(1, 5'd6, mkval(5'd6), 1'b0);
        drive(2, 5'd7, mkval(5'd7), 1'b1);
        step();
        clear_in();
        chk("sq_ready_pre", 64'(fu_ready), 64'h9);
        chk("sq_stall_pre", 64'(is_stall), 64'd1);
        squash = 1'b1;
        drive(0, 5'd8, mkval(5'd8), 1'b0);
        step();
        squash = 1'b0;
        clear_in();
        chk("sq_valid", 64'(cdb_valid), 64'd0);
        chk("sq_ready", 64'(fu_ready), 64'hF);
        chk("sq_stall", 64'(is_stall), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("sq_idle%0d", k), 64'(cdb_valid), 64'd0);
        end
        drive_exp(1, 5'd10);
        drive_exp(2, 5'd11);
        drive_exp(3, 5'd12);
        drive_exp(0, 5'd9);
        drive(0, 5'd9, mkval(5'd9), 1'b1);
        step();
        clear_in();
        step();
        chk("sq_rr_kept", 64'(cdb_tag), 64'd10);
        drain("sq_drain");

        // reset in the middle of a stream (rr_ptr is 1 here)
        drive(0, 5'd20, mkval(5'd20), 1'b0);
        drive_exp(1, 5'd21);
        drive_exp(2, 5'd22);
        drive(3, 5'd23, mkval(5'd23), 1'b1);
        step();
        clear_in();
        step();
        chk("mid_tag1", 64'(cdb_tag), 64'd21);
        step();
        chk("mid_tag2", 64'(cdb_tag), 64'd22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_sb", 64'(sb.size()), 64'd0);
        chk_reset_vals("mid_reset");
        for (int i = 0; i < 4; i++) begin
            drive_exp(i, 5'(24 + i));
        end
        step();
        clear_in();
        step();
        chk("mid_rr_zero", 64'(cdb_tag), 64'd24);
        drain("mid_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
